// File: rtl/dual_timer_core_if.sv
// Bus between the mode/button controller and the dual timer core.
// The controller drives the registered states bus and the BCD load value;
// the core returns the digit buses, the done flags and the buzzer request.
interface dual_timer_core_if;
    logic [9:0]  states;
    logic [15:0] load_val;
    logic [15:0] a_bcd;
    logic [15:0] b_bcd;
    logic        a_done;
    logic        b_done;
    logic        buzzer;

    modport master (
        output states, load_val,
        input  a_bcd, b_bcd, a_done, b_done, buzzer
    );

    modport slave (
        input  states, load_val,
        output a_bcd, b_bcd, a_done, b_done, buzzer
    );
endinterface

// File: rtl/dual_timer_core.sv
// Dual BCD timer: channel A is a 59:59 MM:SS timer stepping once a second,
// channel B is a 999.9 timer stepping every tenth of a second. Both share a
// free-running 0.1 s prescaler and otherwise run completely independently.

// One BCD timer channel. DMAX holds the largest legal value of each digit,
// which is also the up-count terminal value and the load clamp.
module dual_timer_core_chan #(
    parameter logic [15:0] DMAX = 16'h9999
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  ctl,       // {count_up, reset, load, enable}
    input  logic [15:0] load_val,
    input  logic        step,
    output logic [15:0] bcd,
    output logic        done
);
    logic        enable, load, clr, count_up;
    logic [15:0] term, nxt, san;
    logic        at_term;

    assign enable   = ctl[0];
    assign load     = ctl[1];
    assign clr      = ctl[2];
    assign count_up = ctl[3];

    // Clamp each load digit to its legal maximum (>9 -> 9, tens-of -> 5).
    function automatic logic [15:0] sanitise(input logic [15:0] v);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            if (v[i*4 +: 4] > DMAX[i*4 +: 4])
                r[i*4 +: 4] = DMAX[i*4 +: 4];
            else
                r[i*4 +: 4] = v[i*4 +: 4];
        end
        return r;
    endfunction

    // One BCD step with ripple carry (up) or borrow (down), digit maxima from DMAX.
    function automatic logic [15:0] bump(input logic [15:0] v, input logic up);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (up) begin
                    if (v[i*4 +: 4] == DMAX[i*4 +: 4]) begin
                        r[i*4 +: 4] = 4'd0;
                    end else begin
                        r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                        c = 1'b0;
                    end
                end else begin
                    if (v[i*4 +: 4] == 4'd0) begin
                        r[i*4 +: 4] = DMAX[i*4 +: 4];
                    end else begin
                        r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
                        c = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    // Terminal value for the current direction and the candidate next value.
    always_comb begin
        term    = count_up ? DMAX : 16'h0000;
        at_term = (bcd == term);
        nxt     = bump(bcd, count_up);
        san     = sanitise(load_val);
    end

    // Channel state: reset > load > step > hold; done tracks the terminal value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bcd  <= '0;
            done <= 1'b0;
        end else if (clr) begin
            bcd  <= '0;
            done <= 1'b0;
        end else if (load) begin
            bcd  <= san;
            done <= 1'b0;
        end else if (at_term) begin
            // Saturate at the terminal; flag it as soon as the channel is enabled.
            if (enable)
                done <= 1'b1;
        end else if (enable && step && !done) begin
            bcd  <= nxt;
            done <= (nxt == term);
        end else begin
            // Not at the terminal any more (direction flipped): drop done.
            done <= 1'b0;
        end
    end
endmodule

module dual_timer_core #(
    parameter int TICK_DIV = 5_000_000
) (
    input  logic              clk,
    input  logic              reset_n,
    dual_timer_core_if.slave  bus
);
    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] pre_cnt;
    logic [3:0]    div_a;
    logic          tick, step_a, step_b;
    logic [15:0]   a_bcd, b_bcd;
    logic          a_done, b_done;

    assign tick   = (pre_cnt == CW'(TICK_DIV - 1));
    assign step_a = tick && (div_a == 4'd9);
    assign step_b = tick;

    // Free-running 0.1 s prescaler, independent of the states bus.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            pre_cnt <= '0;
        else if (tick)
            pre_cnt <= '0;
        else
            pre_cnt <= pre_cnt + 1'b1;
    end

    // Channel A 1/10 divider; keeps running while A is disabled so the
    // seconds phase survives, and is cleared only by A's reset bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            div_a <= '0;
        else if (bus.states[2])
            div_a <= '0;
        else if (tick)
            div_a <= (div_a == 4'd9) ? 4'd0 : div_a + 4'd1;
    end

    dual_timer_core_chan #(.DMAX(16'h5959)) u_chan_a (
        .clk      (clk),
        .reset_n  (reset_n),
        .ctl      (bus.states[3:0]),
        .load_val (bus.load_val),
        .step     (step_a),
        .bcd      (a_bcd),
        .done     (a_done)
    );

    dual_timer_core_chan #(.DMAX(16'h9999)) u_chan_b (
        .clk      (clk),
        .reset_n  (reset_n),
        .ctl      (bus.states[8:5]),
        .load_val (bus.load_val),
        .step     (step_b),
        .bcd      (b_bcd),
        .done     (b_done)
    );

    assign bus.a_bcd  = a_bcd;
    assign bus.b_bcd  = b_bcd;
    assign bus.a_done = a_done;
    assign bus.b_done = b_done;
    assign bus.buzzer = (a_done & bus.states[4]) | (b_done & bus.states[9]);
endmodule
